ospfb_pattern_src: RTL

Parametrised AXI4-Stream test-pattern source for the OSPFB datapath. It generalises the fixed single-impulse stimulus into four runtime-selectable modes: impulse, step, ramp and alternating tone. It emits exactly `FRAMES*FFT_LEN` complex samples with per-frame `tlast`. It sits ahead of the dual-clock FIFO in the ADC clock domain and drives OSPFB bring-up and capture benches.

---
 rtl/alpaca_ospfb_constants_pkg.sv | 31 +++
 rtl/ospfb_pattern_src.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared types and the sample generator for the OSPFB test-pattern source.
// pattern_value computes at 32 bits; callers keep the low WIDTH bits of each half.
package alpaca_ospfb_constants_pkg;

  typedef enum logic [1:0] {PAT_IMPULSE, PAT_STEP, PAT_RAMP, PAT_TONE} pattern_mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} src_state_t;

  // Returns {im, re}; truncating each half keeps two's-complement semantics for any WIDTH <= 32.
  function automatic logic [63:0] pattern_value(
    input pattern_mode_t mode,
    input logic [31:0]   n,
    input logic [31:0]   p,
    input logic [31:0]   pulse,
    input logic [31:0]   phase
  );
    logic [31:0] re;
    logic [31:0] im;
    re = '0;
    im = '0;
    case (mode)
      PAT_IMPULSE: if (p == phase) begin re = pulse; im = pulse; end
      PAT_STEP:    if (n >= phase) begin re = pulse; im = pulse; end
      PAT_RAMP:    begin re = n; im = -n; end
      PAT_TONE:    re = n[0] ? -pulse : pulse;
      default:     re = '0;
    endcase
    return {im, re};
  endfunction

endpackage

// File: rtl/ospfb_pattern_src.sv
// AXI4-Stream test-pattern source (impulse/step/ramp/tone) for OSPFB bring-up.
// Emits FRAMES*FFT_LEN samples per run with tlast at the end of each frame.
module ospfb_pattern_src
  import alpaca_ospfb_constants_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int FFT_LEN       = 64,
  parameter int FRAMES        = 32,
  parameter int IMPULSE_PHASE = 9,
  parameter int PULSE_VAL     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [1:0]                           mode,
  output logic [2*WIDTH-1:0]                   m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(FRAMES*FFT_LEN+1)-1:0]  sample_cnt
);

  localparam int unsigned SAMP = FRAMES * FFT_LEN;
  localparam int unsigned CW   = $clog2(SAMP + 1);
  localparam int unsigned PW   = $clog2(FFT_LEN);
  localparam int unsigned FW   = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("ospfb_pattern_src: WIDTH must be 1..32");
  end
  if (longint'(PULSE_VAL) < -(longint'(1) <<< (WIDTH - 1)) ||
      longint'(PULSE_VAL) > ((longint'(1) <<< (WIDTH - 1)) - 1)) begin : g_bad_pulse
    $error("ospfb_pattern_src: PULSE_VAL does not fit signed WIDTH");
  end
  if (IMPULSE_PHASE >= FFT_LEN) begin : g_bad_phase
    $error("ospfb_pattern_src: IMPULSE_PHASE must be below FFT_LEN");
  end
  if (FFT_LEN < 2) begin : g_bad_len
    $error("ospfb_pattern_src: FFT_LEN must be at least 2");
  end

  src_state_t    state_q, state_d;
  pattern_mode_t mode_q, mode_sel;
  logic [PW-1:0] p_q, p_nx;
  logic [FW-1:0] f_q, f_nx;
  logic [CW-1:0] cnt_nx;
  logic          hs, last_beat, p_wrap;
  logic          start, adv;
  logic [63:0]   pat_v;
  logic          unused_pat_bits;

  assign hs        = m_axis_tvalid & m_axis_tready;
  assign p_wrap    = (p_q == PW'(FFT_LEN - 1));
  assign last_beat = p_wrap && (f_q == FW'(FRAMES - 1));
  assign p_nx      = p_wrap ? '0 : p_q + PW'(1);
  assign f_nx      = p_wrap ? f_q + FW'(1) : f_q;
  assign cnt_nx    = sample_cnt + CW'(1);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: if (en) begin start = 1'b1; state_d = ST_RUN; end
      ST_RUN: begin
        // en is only honoured at a handshake so the presented beat always completes
        if (hs) begin
          if (last_beat)  state_d = ST_DONE;
          else if (!en)   state_d = ST_IDLE;
          else            adv = 1'b1;
        end
      end
      ST_DONE: if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_sel = start ? pattern_mode_t'(mode) : mode_q;
    pat_v    = pattern_value(mode_sel,
                             start ? 32'd0 : 32'(cnt_nx),
                             start ? 32'd0 : 32'(p_nx),
                             32'(PULSE_VAL), 32'(IMPULSE_PHASE));
  end

  assign unused_pat_bits = ^pat_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= PAT_IMPULSE;
      p_q           <= '0;
      f_q           <= '0;
      sample_cnt    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy <= (state_d == ST_RUN);
      done <= (state_d == ST_DONE);
      if (start) begin
        mode_q        <= pattern_mode_t'(mode);
        p_q           <= '0;
        f_q           <= '0;
        sample_cnt    <= '0;
        m_axis_tdata  <= {pat_v[32 +: WIDTH], pat_v[0 +: WIDTH]};
        m_axis_tlast  <= 1'b0;
        m_axis_tvalid <= 1'b1;
      end else if (adv) begin
        p_q          <= p_nx;
        f_q          <= f_nx;
        sample_cnt   <= cnt_nx;
        m_axis_tdata <= {pat_v[32 +: WIDTH], pat_v[0 +: WIDTH]};
        m_axis_tlast <= (p_nx == PW'(FFT_LEN - 1));
      end else if (state_q == ST_RUN && hs) begin
        m_axis_tvalid <= 1'b0;
        if (state_d == ST_DONE) begin
          sample_cnt <= cnt_nx;
        end else begin
          p_q        <= '0;
          f_q        <= '0;
          sample_cnt <= '0;
        end
      end
    end
  end

endmodule
